// File: rtl/memory_access_unit.sv
// Load/store sequencer: computes base+offset, issues one held memory request, returns byte/word data.
// Optional MEM_ALIGN_CHECK_EN: misaligned word accesses fault instead of being silently aligned.
module memory_access_unit #(
    parameter int WORD = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            we_i,
    input  logic            byte_i,
    input  logic            pre_i,
    input  logic [WORD-1:0] base_i,
    input  logic [WORD-1:0] offset_i,
    input  logic [WORD-1:0] wdata_i,
    input  logic            mem_ack_i,
    input  logic [WORD-1:0] mem_rdata_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [1:0]      mem_be_o,
    output logic [WORD-1:0] mem_addr_o,
    output logic [WORD-1:0] mem_wdata_o,
    output logic [WORD-1:0] rdata_o,
    output logic [WORD-1:0] addr_upd_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            fault_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic            byte_q, byte_d;
    logic            fault_q, fault_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic [WORD-1:0] ea_q, ea_d;
    logic [WORD-1:0] upd_q, upd_d;
    logic [WORD-1:0] rdata_q, rdata_d;

    logic [WORD-1:0] upd_sum;
    logic [WORD-1:0] ea_raw;
    logic [WORD-1:0] wdata_lane;
    logic [WORD-1:0] rdata_lane;

    // Carry out of the add is dropped by the WORD-wide result.
    assign upd_sum = base_i + offset_i;
    assign ea_raw  = pre_i ? upd_sum : base_i;

    always_comb begin
        wdata_lane = '0;
        if (byte_i) begin
            wdata_lane[15:8] = wdata_i[7:0];
            wdata_lane[7:0]  = wdata_i[7:0];
        end else begin
            wdata_lane = wdata_i;
        end
    end

    always_comb begin
        rdata_lane = '0;
        if (byte_q) begin
            rdata_lane[7:0] = ea_q[0] ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
        end else begin
            rdata_lane = mem_rdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        byte_d  = byte_q;
        fault_d = fault_q;
        wdata_d = wdata_q;
        ea_d    = ea_q;
        upd_d   = upd_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    we_d    = we_i;
                    byte_d  = byte_i;
                    wdata_d = wdata_lane;
                    upd_d   = upd_sum;
                    ea_d    = ea_raw;
                    fault_d = 1'b0;
                    state_d = REQ;
`ifdef MEM_ALIGN_CHECK_EN
                    if (!byte_i && ea_raw[0]) begin
                        fault_d = 1'b1;
                        state_d = DONE;
                    end
`else
                    if (!byte_i) ea_d[0] = 1'b0;
`endif
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = rdata_lane;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            fault_q <= 1'b0;
            wdata_q <= '0;
            ea_q    <= '0;
            upd_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            fault_q <= fault_d;
            wdata_q <= wdata_d;
            ea_q    <= ea_d;
            upd_q   <= upd_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes are qualified by REQ so nothing reaches memory outside a request.
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_be_o    = !mem_req_o ? 2'b00 :
                         !byte_q    ? 2'b11 :
                         ea_q[0]    ? 2'b10 : 2'b01;
    assign mem_addr_o  = ea_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign addr_upd_o  = upd_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE) && !fault_q;
    assign fault_o     = (state_q == DONE) && fault_q;

endmodule
